// File: rtl/gameplay_pkg.sv
// Shared constants and types for the gameplay tick/input front end.
package gameplay_pkg;

  localparam logic [1:0] MODE_PLAY = 2'b01;

  localparam int NUM_BTN    = 4;
  localparam int BTN_LEFT   = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_ROTATE = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Gravity period for a speed level, floored at 2 so the counter always has a
  // non-zero phase between pulses even at aggressive shift amounts.
  function automatic int unsigned drop_period(input int unsigned drop, input logic [1:0] lvl);
    int unsigned p;
    p = drop >> lvl;
    if (p < 2) p = 2;
    return p;
  endfunction

endpackage

// File: rtl/gameplay_tick_input_if.sv
// Signal bundle between the gameplay front end and its surroundings.
interface gameplay_tick_input_if;
  logic [1:0] mode;
  logic [3:0] btn_n;
  logic [1:0] speed_level;
  logic       SecEn;
  logic       adjustSecEn;
  logic       left;
  logic       down;
  logic       right;
  logic       rotate;

  modport master (
    output mode, btn_n, speed_level,
    input  SecEn, adjustSecEn, left, down, right, rotate
  );

  modport slave (
    input  mode, btn_n, speed_level,
    output SecEn, adjustSecEn, left, down, right, rotate
  );
endinterface

// File: rtl/gameplay_tick_input_key_debounce.sv
// Two-flop synchronizer and stable-count debouncer for one active-low button;
// produces an active-high level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 26
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic btn_n,
  output logic level
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             pressed;
  logic [CNT_W-1:0] cnt;

  assign pressed = ~sync_b;

  // Sync flops come out of reset released so no phantom press is seen.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= btn_n;
      sync_b <= sync_a;
      if (pressed == level) begin
        cnt <= '0;
      end else if (cnt >= TERM) begin
        level <= pressed;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gameplay_tick_input.sv
// Timing and key front end for the gameplay FSM: debounced keys, gravity tick
// and auto-repeat tick, with both ticks gated to play mode.
//
// state  | meaning
// IDLE   | no key held or not in play; repeat counter parked at 0
// FIRST  | key held, waiting out the initial delay
// REPEAT | initial delay done, pulsing every REPEAT_CYCLES
module gameplay_tick_input
  import gameplay_pkg::*;
#(
  parameter int DROP_CYCLES     = 50_000_000,
  parameter int INITIAL_DELAY   = 15_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 26
) (
  input logic                  Clk,
  input logic                  Resetn,
  gameplay_tick_input_if.slave gif
);

  localparam logic [CNT_W-1:0] FIRST_TERM  = CNT_W'(INITIAL_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_BTN-1:0] key;
  logic [NUM_BTN-1:0] key_d;
  logic               play;
  logic               held;
  logic               rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .Clk   (Clk),
      .Resetn(Resetn),
      .btn_n (gif.btn_n[i]),
      .level (key[i])
    );
  end

  assign play = (gif.mode == MODE_PLAY);
  assign held = |key;
  assign rise = |(key & ~key_d);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) key_d <= '0;
    else         key_d <= key;
  end

  assign gif.left   = key[BTN_LEFT];
  assign gif.down   = key[BTN_DOWN];
  assign gif.right  = key[BTN_RIGHT];
  assign gif.rotate = key[BTN_ROTATE];

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] grav_cnt;
  logic             sec_q;

  assign period = CNT_W'(drop_period(DROP_CYCLES, gif.speed_level));

  // >= so that a shorter period chosen mid-count fires on the next edge.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      grav_cnt <= '0;
      sec_q    <= 1'b0;
    end else if (!play) begin
      grav_cnt <= '0;
      sec_q    <= 1'b0;
    end else if (grav_cnt >= period - 1'b1) begin
      grav_cnt <= '0;
      sec_q    <= 1'b1;
    end else begin
      grav_cnt <= grav_cnt + 1'b1;
      sec_q    <= 1'b0;
    end
  end

  assign gif.SecEn = sec_q & play;

  rpt_state_t       state;
  rpt_state_t       state_nxt;
  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_cnt_nxt;
  logic             adj;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
    end
  end

  // A newly pressed key always gets a full initial delay, even mid-repeat.
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    adj         = 1'b0;
    if (!held || !play) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
    end else if (rise || state == IDLE) begin
      state_nxt   = FIRST;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        FIRST: begin
          if (rpt_cnt >= FIRST_TERM) begin
            adj         = 1'b1;
            state_nxt   = REPEAT;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rpt_cnt >= REPEAT_TERM) begin
            adj         = 1'b1;
            rpt_cnt_nxt = '0;
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign gif.adjustSecEn = adj;

endmodule

// File: tb/tb_gameplay_tick_input.sv
// Scoreboard bench for gameplay_tick_input: directed scenarios plus random
// stimulus, checked against an event-level reference model.
module tb_gameplay_tick_input;

  localparam int DROP = 20;
  localparam int INIT = 8;
  localparam int REP  = 4;
  localparam int DEB  = 3;
  localparam int CW   = 8;

  logic Clk    = 1'b0;
  logic Resetn = 1'b0;

  gameplay_tick_input_if gif ();

  gameplay_tick_input #(
    .DROP_CYCLES    (DROP),
    .INITIAL_DELAY  (INIT),
    .REPEAT_CYCLES  (REP),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .Clk   (Clk),
    .Resetn(Resetn),
    .gif   (gif)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       sec;
    logic       adj;
    logic [3:0] lvl;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: raw sample history, key levels, gravity phase,
  // and the start cycle of the current auto-repeat schedule.
  logic [DEB:0] hist [4];
  logic [3:0]   m_lvl;
  logic [3:0]   m_prev;
  int           el;
  int           t0;
  int           cyc;
  bit           m_sec;
  bit           active;

  function automatic int period_of(input logic [1:0] s);
    int p;
    p = DROP >> s;
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) hist[b] = '1;
    m_lvl  = 4'h0;
    m_prev = 4'h0;
    el     = 0;
    m_sec  = 1'b0;
    active = 1'b0;
  endtask

  task automatic model_edge();
    logic       play;
    logic [3:0] old;
    logic       all_diff;
    play = (gif.mode == 2'b01);
    old  = m_lvl;
    if (old == 4'h0 || !play) active = 1'b0;
    else if (!active || (old & ~m_prev) != 4'h0) begin
      active = 1'b1;
      t0     = cyc + 1;
    end
    if (!play) begin
      el    = 0;
      m_sec = 1'b0;
    end else if (el >= period_of(gif.speed_level) - 1) begin
      el    = 0;
      m_sec = 1'b1;
    end else begin
      el++;
      m_sec = 1'b0;
    end
    // A level flips once the synchronized value has disagreed with it for DEB edges.
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= DEB; j++) if (!hist[b][j] == m_lvl[b]) all_diff = 1'b0;
      if (all_diff) m_lvl[b] = ~m_lvl[b];
      hist[b] = {hist[b][DEB-1:0], gif.btn_n[b]};
    end
    m_prev = old;
    cyc++;
  endtask

  task automatic push_expected();
    exp_t e;
    logic play;
    int   d;
    play  = (gif.mode == 2'b01);
    e.lvl = m_lvl;
    e.sec = m_sec && play;
    e.adj = 1'b0;
    if (active && play && m_lvl != 4'h0 && (m_lvl & ~m_prev) == 4'h0) begin
      d = cyc - t0;
      if (d == INIT - 1 || (d > INIT - 1 && (d - (INIT - 1)) % REP == 0)) e.adj = 1'b1;
    end
    expq.push_back(e);
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step(input logic [1:0] md, input logic [3:0] bt, input logic [1:0] sp, input logic rb);
    @(posedge Clk);
    if (Resetn) model_edge();
    else model_reset();
    #2;
    gif.mode        = md;
    gif.btn_n       = bt;
    gif.speed_level = sp;
    if (Resetn && !rb) begin
      Resetn = 1'b0;
      model_reset();
      #1;
      check_eq("outputs under async reset",
               int'({gif.SecEn, gif.adjustSecEn, gif.rotate, gif.right, gif.down, gif.left}), 0);
    end else begin
      Resetn = rb;
    end
    if (!Resetn) model_reset();
    push_expected();
  endtask

  task automatic hold();
    step(gif.mode, gif.btn_n, gif.speed_level, Resetn);
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return gif.SecEn;
      1:       return gif.adjustSecEn;
      2:       return gif.left;
      3:       return gif.right;
      default: return gif.down;
    endcase
  endfunction

  task automatic count_until(input int which, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      hold();
      #1;
      if (pick(which) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge Clk);
      if (expq.size() != 0) begin
        e   = expq.pop_front();
        act = {gif.SecEn, gif.adjustSecEn, gif.rotate, gif.right, gif.down, gif.left};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got sec=%b adj=%b keys=%b, expected sec=%b adj=%b keys=%b",
                   $time, act[5], act[4], act[3:0], e.sec, e.adj, e.lvl);
        end
      end
    end
  end

  initial begin : stimulus
    int         n;
    int         n2;
    int         len;
    int         gl;
    logic [1:0] md;
    logic [1:0] sp;
    logic [3:0] bt;
    logic [3:0] g;
    logic       rb;

    gif.mode        = 2'b00;
    gif.btn_n       = 4'hF;
    gif.speed_level = 2'd0;
    cyc             = 0;
    t0              = 0;
    model_reset();

    repeat (3) step(2'b00, 4'hF, 2'd0, 1'b0);
    repeat (6) step(2'b00, 4'hF, 2'd0, 1'b1);

    // Gravity at speed 0, first pulse timing from mode entry.
    step(2'b01, 4'hF, 2'd0, 1'b1);
    count_until(0, 60, n);
    check_eq("first SecEn after mode entry", n, DROP);
    repeat (45) hold();

    // Speed changes in both directions mid-count.
    step(2'b01, 4'hF, 2'd2, 1'b1);
    repeat (8) hold();
    step(2'b01, 4'hF, 2'd0, 1'b1);
    repeat (30) hold();
    step(2'b01, 4'hF, 2'd2, 1'b1);
    repeat (20) hold();
    step(2'b01, 4'hF, 2'd0, 1'b1);

    // Short press rejected, real press accepted, short release rejected.
    step(2'b01, 4'hE, 2'd0, 1'b1);
    step(2'b01, 4'hE, 2'd0, 1'b1);
    step(2'b01, 4'hF, 2'd0, 1'b1);
    repeat (8) hold();
    step(2'b01, 4'hE, 2'd0, 1'b1);
    count_until(2, 20, n);
    check_eq("left debounce latency", n, DEB + 2);
    step(2'b01, 4'hF, 2'd0, 1'b1);
    step(2'b01, 4'hF, 2'd0, 1'b1);
    step(2'b01, 4'hE, 2'd0, 1'b1);
    repeat (8) hold();
    step(2'b01, 4'hF, 2'd0, 1'b1);
    repeat (8) hold();

    // Auto-repeat on right, then a second key restarts the initial delay.
    step(2'b01, 4'hB, 2'd0, 1'b1);
    count_until(3, 20, n);
    check_eq("right debounce latency", n, DEB + 2);
    count_until(1, 20, n);
    check_eq("first adjustSecEn after right", n, INIT);
    count_until(1, 20, n);
    check_eq("repeat adjustSecEn interval", n, REP);
    repeat (6) hold();
    step(2'b01, 4'h9, 2'd0, 1'b1);
    count_until(4, 20, n);
    check_eq("down debounce latency", n, DEB + 2);
    count_until(1, 20, n);
    check_eq("adjustSecEn after down restart", n, INIT);
    step(2'b01, 4'hF, 2'd0, 1'b1);
    repeat (20) hold();

    // Leave play mid-count with a key held, then re-enter.
    step(2'b01, 4'hE, 2'd0, 1'b1);
    repeat (10) hold();
    step(2'b00, 4'hE, 2'd0, 1'b1);
    repeat (12) hold();
    step(2'b01, 4'hE, 2'd0, 1'b1);
    count_until(0, 40, n);
    check_eq("first SecEn after re-entry", n, DROP);

    // Async reset mid-hold and mid-count; key must re-debounce afterwards.
    repeat (7) hold();
    step(2'b01, 4'hE, 2'd0, 1'b0);
    step(2'b01, 4'hE, 2'd0, 1'b0);
    step(2'b01, 4'hE, 2'd0, 1'b1);
    count_until(2, 20, n);
    check_eq("left latency after reset release", n, DEB + 2);
    count_until(0, 40, n2);
    check_eq("first SecEn after reset release", n + n2, DROP);
    step(2'b01, 4'hF, 2'd0, 1'b1);
    repeat (10) hold();

    // Random segments: modes, speeds, key combinations, glitches, resets.
    repeat (120) begin
      md = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
      sp = 2'($urandom_range(0, 3));
      bt = 4'hF;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) < 3) bt[b] = 1'b0;
      len = $urandom_range(1, 40);
      rb  = ($urandom_range(0, 39) != 0);
      step(md, bt, sp, rb);
      if (!rb) begin
        step(md, bt, sp, 1'b0);
        step(md, bt, sp, 1'b1);
      end
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          g  = 4'(1 << $urandom_range(0, 3));
          gl = $urandom_range(1, DEB);
          repeat (gl) step(md, bt ^ g, sp, 1'b1);
          step(md, bt, sp, 1'b1);
        end else begin
          hold();
        end
      end
    end

    @(negedge Clk);
    #1;
    check_eq("scoreboard drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
